// File: rtl/free_list_pkg.sv
// Shared sizing, tag types and pointer helpers for the physical-register free list.
// The parameters here set the width of every interface and module in the block.
package free_list_pkg;

   localparam int unsigned N_WAY         = 2;
   localparam int unsigned N_ROB         = 32;
   localparam int unsigned N_PHYS_REG    = 64;
   localparam int unsigned N_ARCH_REG    = 32;
   localparam int unsigned CDB_BITS      = $clog2(N_PHYS_REG);
   localparam int unsigned FL_DEPTH      = N_PHYS_REG - N_ARCH_REG;
   localparam int unsigned PTR_BITS      = $clog2(FL_DEPTH);
   localparam int unsigned CNT_BITS      = $clog2(FL_DEPTH) + 1;
   localparam int unsigned NUM_BITS      = $clog2(N_WAY) + 1;
   localparam int unsigned N_CAND        = N_WAY + N_ROB;
   localparam int unsigned CAND_CNT_BITS = $clog2(N_CAND + 1);

   typedef logic [CDB_BITS-1:0] tag_t;
   typedef logic [PTR_BITS-1:0] ptr_t;
   typedef logic [CNT_BITS-1:0] cnt_t;

   // The architectural zero register stays identity-mapped and must never be recycled.
   localparam tag_t ZERO_REG_PR = tag_t'(31);

   function automatic ptr_t ptr_add(ptr_t p, int unsigned n);
      int unsigned sum;
      sum = (32'(p) + n) % FL_DEPTH;
      return ptr_t'(sum);
   endfunction

   function automatic logic is_real_tag(tag_t t);
      return (t != '0) && (t != ZERO_REG_PR);
   endfunction

endpackage

// File: rtl/free_list_if.sv
// ROB/dispatch-facing signals of the free list. The free list itself is the slave;
// the ROB plus rename/dispatch logic together form the master.
interface free_list_if;
   import free_list_pkg::*;

   logic [N_WAY-1:0]    retire_valid;
   tag_t [N_WAY-1:0]    retire_told;
   logic                branch_haz;
   tag_t [N_ROB-1:0]    free_list_haz;
   logic [N_WAY-1:0]    dispatch_req;
   tag_t [N_WAY-1:0]    free_tag;
   logic [N_WAY-1:0]    free_tag_valid;
   logic [NUM_BITS-1:0] free_num;
   cnt_t                free_count;

   modport master (
      output retire_valid, retire_told, branch_haz, free_list_haz, dispatch_req,
      input  free_tag, free_tag_valid, free_num, free_count
   );

   modport slave (
      input  retire_valid, retire_told, branch_haz, free_list_haz, dispatch_req,
      output free_tag, free_tag_valid, free_num, free_count
   );

endinterface

// File: rtl/fl_compact.sv
// Packs the surviving candidate tags (valid, nonzero, not the zero register) into a
// dense list in candidate order and reports how many survived.
module fl_compact
   import free_list_pkg::*;
(
   input  tag_t [N_CAND-1:0]        cand_i,
   input  logic [N_CAND-1:0]        cand_vld_i,
   output tag_t [N_CAND-1:0]        list_o,
   output logic [CAND_CNT_BITS-1:0] cnt_o
);

   logic [CAND_CNT_BITS-1:0] idx;

   always_comb begin
      list_o = '0;
      idx    = '0;
      for (int unsigned i = 0; i < N_CAND; i++) begin
         if (cand_vld_i[i] && is_real_tag(cand_i[i])) begin
            list_o[idx] = cand_i[i];
            idx         = idx + CAND_CNT_BITS'(1);
         end
      end
      cnt_o = idx;
   end

endmodule

// File: rtl/free_list.sv
// Circular FIFO of free physical tags: retire/squash pushes at the tail, up to N_WAY
// pops per cycle at the head for rename. Reset refills it with the non-architectural tags.
module free_list
   import free_list_pkg::*;
(
   input logic        clock_i,
   input logic        reset_i,
   free_list_if.slave fl_io
);

   tag_t entry_q [FL_DEPTH];
   tag_t entry_d [FL_DEPTH];
   ptr_t head_q, head_d;
   ptr_t tail_q, tail_d;
   cnt_t count_q, count_d;

   logic [N_WAY-1:0]         tag_valid;
   logic [N_WAY-1:0]         pop_lanes;
   logic [NUM_BITS-1:0]      pop_cnt;
   tag_t [N_CAND-1:0]        cand;
   logic [N_CAND-1:0]        cand_vld;
   tag_t [N_CAND-1:0]        push_list;
   logic [CAND_CNT_BITS-1:0] push_cnt;
   int unsigned              room;
   int unsigned              push_acc;
   logic                     overflow;

   // Read side: straight from registers, so a push is visible only after the edge.
   always_comb begin
      for (int unsigned i = 0; i < N_WAY; i++) begin
         fl_io.free_tag[i] = entry_q[ptr_add(head_q, i)];
         tag_valid[i]      = (32'(count_q) > i);
      end
      fl_io.free_tag_valid = tag_valid;
      fl_io.free_num       = (32'(count_q) >= N_WAY) ? NUM_BITS'(N_WAY) : NUM_BITS'(count_q);
      fl_io.free_count     = count_q;
   end

   // The front end is squashed on a hazard cycle, so nothing is handed out.
   always_comb begin
      pop_lanes = fl_io.branch_haz ? '0 : (fl_io.dispatch_req & tag_valid);
      pop_cnt   = '0;
      for (int unsigned i = 0; i < N_WAY; i++) begin
         pop_cnt = pop_cnt + NUM_BITS'(pop_lanes[i]);
      end
   end

   assign cand     = {fl_io.free_list_haz, fl_io.retire_told};
   assign cand_vld = {{N_ROB{fl_io.branch_haz}}, fl_io.retire_valid};

   fl_compact u_compact (
      .cand_i     (cand),
      .cand_vld_i (cand_vld),
      .list_o     (push_list),
      .cnt_o      (push_cnt)
   );

   always_comb begin
      entry_d  = entry_q;
      room     = FL_DEPTH - 32'(count_q) + 32'(pop_cnt);
      overflow = 32'(push_cnt) > room;
      push_acc = overflow ? room : 32'(push_cnt);
      // Excess pushes beyond the free room are dropped from the end of push order.
      for (int unsigned j = 0; j < N_CAND; j++) begin
         if (j < push_acc) begin
            entry_d[ptr_add(tail_q, j)] = push_list[j];
         end
      end
      head_d  = ptr_add(head_q, 32'(pop_cnt));
      tail_d  = ptr_add(tail_q, push_acc);
      count_d = cnt_t'(32'(count_q) - 32'(pop_cnt) + push_acc);
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         for (int unsigned k = 0; k < FL_DEPTH; k++) begin
            entry_q[k] <= tag_t'(N_ARCH_REG + k);
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= cnt_t'(FL_DEPTH);
      end else begin
         entry_q <= entry_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Protocol checks; none of these has a hardware consequence beyond what is above.
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         assert (!overflow)
            else $error("free_list: overflow, %0d tag(s) dropped", 32'(push_cnt) - room);
         assert ((fl_io.dispatch_req & (fl_io.dispatch_req + N_WAY'(1))) == '0)
            else $error("free_list: non-prefix dispatch_req %b", fl_io.dispatch_req);
         for (int unsigned j = 0; j < N_CAND; j++) begin
            for (int unsigned k = 0; k < FL_DEPTH; k++) begin
               if ((j < push_acc) && (k >= 32'(pop_cnt)) && (k < 32'(count_q))) begin
                  assert (entry_q[ptr_add(head_q, k)] != push_list[j])
                     else $error("free_list: duplicate tag %0d pushed", push_list[j]);
               end
            end
         end
      end
   end

endmodule
